add2_serial_ctrl: RTL and testbench

Sequencing controller that computes a WIDTH-bit unsigned sum by running a 2-bit adder slice once per cycle for WIDTH/2 cycles, least-significant pair first, with the carry chained between cycles. It sits between a valid/ready operand source and a valid/ready result sink. This lets one small 2-bit add datapath serve arbitrarily wide operands at the cost of latency.

---
 rtl/add2_serial_ctrl.sv | 106 ++++++++++
 tb/tb_add2_serial_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add2_serial_ctrl.sv
// Serial adder controller: sums two WIDTH-bit operands with one 2-bit adder slice,
// processing one bit pair per cycle, LSB pair first, with the carry chained between cycles.
module add2_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int PAIRS = WIDTH / 2;
    localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [2:0]       slice;
    logic [WIDTH-1:0] rsShift;

    assign slice = {1'b0, ra_q[1:0]} + {1'b0, rb_q[1:0]} + {2'b00, c_q};

    // New pair enters at the top so the first (least-significant) pair lands in bits [1:0].
    if (WIDTH == 2) begin : g_narrow
        assign rsShift = slice[1:0];
    end else begin : g_wide
        assign rsShift = {slice[1:0], rs_q[WIDTH-1:2]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rs_q    <= rs_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rs_d      = rs_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ra_d    = a;
                    rb_d    = b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                rs_d  = rsShift;
                ra_d  = ra_q >> 2;
                rb_d  = rb_q >> 2;
                c_d   = slice[2];
                cnt_d = cnt_q + CW'(1);
                // The edge leaving RUN also performs the final slice.
                if (cnt_q == CW'(PAIRS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum  = rs_q;
    assign cout = c_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_add2_serial_ctrl.sv
// Self-checking bench for add2_serial_ctrl at WIDTH 8, 2 and 16, using directed
// tables, hand-written handshake sequences and randomized ops against a plain a+b model.
module tb_add2_serial_ctrl;

    logic clk;
    logic rst;

    logic        inValid8, inReady8, outValid8, outReady8, cout8, busy8;
    logic [7:0]  a8, b8, sum8;
    logic        inValid2, inReady2, outValid2, outReady2, cout2, busy2;
    logic [1:0]  a2, b2, sum2;
    logic        inValid16, inReady16, outValid16, outReady16, cout16, busy16;
    logic [15:0] a16, b16, sum16;

    int checkCount = 0;
    int passCount  = 0;

    add2_serial_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(inValid8), .in_ready(inReady8), .a(a8), .b(b8),
        .out_valid(outValid8), .out_ready(outReady8), .sum(sum8), .cout(cout8), .busy(busy8)
    );

    add2_serial_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(inValid2), .in_ready(inReady2), .a(a2), .b(b2),
        .out_valid(outValid2), .out_ready(outReady2), .sum(sum2), .cout(cout2), .busy(busy2)
    );

    add2_serial_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(inValid16), .in_ready(inReady16), .a(a16), .b(b16),
        .out_valid(outValid16), .out_ready(outReady16), .sum(sum16), .cout(cout16), .busy(busy16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expSum;
        logic       expCout;
        int         hold;
        bit         toggle;
    } vec8_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // One full WIDTH=8 transaction; holds out_ready low for 'hold' cycles once DONE is reached.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] expSum,
                                 input logic expCout, input int hold, input bit toggle, input string tag);
        int lat;
        checkOutput({tag, "_in_ready_idle"}, 32'(inReady8), 32'd1);
        inValid8  = 1'b1;
        a8        = av;
        b8        = bv;
        outReady8 = (hold == 0);
        tick();
        inValid8 = 1'b0;
        lat = 0;
        while (!outValid8 && lat < 20) begin
            if (toggle) begin
                inValid8 = 1'($urandom);
                a8       = 8'($urandom);
                b8       = 8'($urandom);
            end
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
        checkOutput({tag, "_sum"}, 32'(sum8), 32'(expSum));
        checkOutput({tag, "_cout"}, 32'(cout8), 32'(expCout));
        checkOutput({tag, "_busy"}, 32'(busy8), 32'd1);
        for (int i = 0; i < hold; i++) begin
            if (toggle) begin
                inValid8 = 1'($urandom);
                a8       = 8'($urandom);
                b8       = 8'($urandom);
            end
            tick();
            checkOutput({tag, "_hold_valid"}, 32'(outValid8), 32'd1);
            checkOutput({tag, "_hold_sum"}, 32'(sum8), 32'(expSum));
            checkOutput({tag, "_hold_cout"}, 32'(cout8), 32'(expCout));
        end
        inValid8  = 1'b0;
        outReady8 = 1'b1;
        tick();
        checkOutput({tag, "_in_ready_after"}, 32'(inReady8), 32'd1);
        checkOutput({tag, "_out_valid_after"}, 32'(outValid8), 32'd0);
        checkOutput({tag, "_busy_after"}, 32'(busy8), 32'd0);
    endtask

    initial begin
        vec8_t       vecs[7];
        logic [7:0]  pairA[3];
        logic [7:0]  pairB[3];
        logic [8:0]  expQ[$];
        int          acceptCyc[$];
        int          cyc, idx, results, lat, pulses;
        bit          willAccept;
        logic [8:0]  exp8;
        logic [16:0] exp16;
        logic [15:0] av16, bv16;
        int          hold16;

        vecs[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0, 0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 0, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 0, 1'b0};
        vecs[3] = '{8'h12, 8'h34, 8'h46, 1'b0, 5, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 8'h00, 1'b1, 2, 1'b0};
        vecs[6] = '{8'h55, 8'hAB, 8'h00, 1'b1, 1, 1'b1};

        rst = 1'b1;
        inValid8 = 1'b0;  a8 = '0;  b8 = '0;  outReady8 = 1'b1;
        inValid2 = 1'b0;  a2 = '0;  b2 = '0;  outReady2 = 1'b1;
        inValid16 = 1'b0; a16 = '0; b16 = '0; outReady16 = 1'b1;
        #3;
        checkOutput("reset_in_ready", 32'(inReady8), 32'd1);
        checkOutput("reset_out_valid", 32'(outValid8), 32'd0);
        checkOutput("reset_busy", 32'(busy8), 32'd0);
        checkOutput("reset_sum", 32'(sum8), 32'd0);
        checkOutput("reset_cout", 32'(cout8), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] directed vector table, WIDTH=8");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expSum, vecs[i].expCout,
                          vecs[i].hold, vecs[i].toggle, $sformatf("vec%0d", i));
        end

        $display("[TB] reset during RUN");
        inValid8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        tick();
        inValid8 = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checkOutput("midrun_in_ready", 32'(inReady8), 32'd1);
        checkOutput("midrun_out_valid", 32'(outValid8), 32'd0);
        checkOutput("midrun_busy", 32'(busy8), 32'd0);
        checkOutput("midrun_sum", 32'(sum8), 32'd0);
        checkOutput("midrun_cout", 32'(cout8), 32'd0);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (outValid8) pulses++;
        end
        checkOutput("midrun_no_pulse", 32'(pulses), 32'd0);
        applyStimulus(8'h01, 8'h02, 8'h03, 1'b0, 0, 1'b0, "after_reset");

        $display("[TB] back-to-back with in_valid held high");
        pairA[0] = 8'h5A; pairB[0] = 8'hC3;
        pairA[1] = 8'hFF; pairB[1] = 8'h01;
        pairA[2] = 8'h17; pairB[2] = 8'h29;
        idx = 0; cyc = 0; results = 0;
        inValid8 = 1'b1; a8 = pairA[0]; b8 = pairB[0]; outReady8 = 1'b1;
        while ((idx < 3 || expQ.size() > 0) && cyc < 60) begin
            willAccept = inReady8 && inValid8;
            tick();
            cyc++;
            if (willAccept) begin
                acceptCyc.push_back(cyc);
                expQ.push_back({1'b0, a8} + {1'b0, b8});
                idx++;
                if (idx < 3) begin
                    a8 = pairA[idx];
                    b8 = pairB[idx];
                end else begin
                    inValid8 = 1'b0;
                end
            end
            if (outValid8) begin
                if (expQ.size() > 0) begin
                    exp8 = expQ.pop_front();
                    checkOutput("b2b_result", 32'({cout8, sum8}), 32'(exp8));
                    results++;
                end else begin
                    checkOutput("b2b_unexpected_result", 32'd1, 32'd0);
                end
            end
        end
        inValid8 = 1'b0;
        checkOutput("b2b_result_count", 32'(results), 32'd3);
        checkOutput("b2b_accept_count", 32'(acceptCyc.size()), 32'd3);
        for (int i = 1; i < acceptCyc.size(); i++) begin
            checkOutput("b2b_accept_spacing", 32'(acceptCyc[i] - acceptCyc[i-1]), 32'd6);
        end
        tick();

        $display("[TB] exhaustive WIDTH=2");
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                inValid2 = 1'b1; a2 = 2'(x); b2 = 2'(y);
                tick();
                inValid2 = 1'b0;
                lat = 0;
                while (!outValid2 && lat < 10) begin
                    tick();
                    lat++;
                end
                checkOutput("w2_latency", 32'(lat), 32'd1);
                checkOutput("w2_result", 32'({cout2, sum2}), 32'(x + y));
                tick();
                checkOutput("w2_in_ready_after", 32'(inReady2), 32'd1);
            end
        end

        $display("[TB] random ops, WIDTH=16");
        for (int n = 0; n < 1000; n++) begin
            av16 = (n == 0) ? 16'hFFFF : (n == 1) ? 16'hFFFF : 16'($urandom);
            bv16 = (n == 0) ? 16'hFFFF : (n == 1) ? 16'h0001 : 16'($urandom);
            hold16 = $urandom_range(0, 2);
            exp16 = 17'(av16) + 17'(bv16);
            inValid16 = 1'b1; a16 = av16; b16 = bv16; outReady16 = (hold16 == 0);
            tick();
            inValid16 = 1'b0;
            lat = 0;
            while (!outValid16 && lat < 30) begin
                tick();
                lat++;
            end
            checkOutput("w16_latency", 32'(lat), 32'd8);
            checkOutput("w16_result", 32'({cout16, sum16}), 32'(exp16));
            for (int i = 0; i < hold16; i++) begin
                tick();
            end
            if (hold16 > 0) begin
                checkOutput("w16_hold_result", 32'({outValid16, cout16, sum16}), 32'({1'b1, exp16}));
            end
            outReady16 = 1'b1;
            tick();
            checkOutput("w16_in_ready_after", 32'(inReady16), 32'd1);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
